// File: rtl/rob_marker_pkg.sv
// rtl/rob_marker_pkg.sv - shared INFO marker constants, codes and event record
package rob_marker_pkg;

    localparam logic [31:0] INFO_BASE     = 32'h00002013;
    localparam int          INFO_CODE_LSB = 20;
    localparam logic [3:0]  INFO_CODE_MAX = 4'hD;
    localparam int          EVT_ID_MAX_W  = 32;

    // Even codes open a region, odd codes close it.
    typedef enum logic [3:0] {
        VCTM_START  = 4'd0,
        VCTM_END    = 4'd1,
        SYNC_START  = 4'd2,
        SYNC_END    = 4'd3,
        FENCE_START = 4'd4,
        FENCE_END   = 4'd5,
        IRQ_START   = 4'd6,
        IRQ_END     = 4'd7,
        WARM_START  = 4'd8,
        WARM_END    = 4'd9,
        MEAS_START  = 4'd10,
        MEAS_END    = 4'd11,
        TRAIN_START = 4'd12,
        TRAIN_END   = 4'd13
    } marker_code_e;

    typedef struct packed {
        marker_code_e              code;
        logic [1:0]                lane;
        logic [EVT_ID_MAX_W-1:0]   id;
        logic [31:0]               cycle;
    } marker_evt_t;

endpackage

// File: rtl/rob_marker_serializer_if.sv
// rtl/rob_marker_serializer_if.sv - marker event stream towards the sync monitor
interface rob_marker_serializer_if #(
    parameter int ID_W = 16
);
    logic            evt_valid;
    logic            evt_ready;
    logic [3:0]      evt_code;
    logic [1:0]      evt_lane;
    logic [ID_W-1:0] evt_id;
    logic [31:0]     evt_cycle;

    modport master (
        output evt_valid, evt_code, evt_lane, evt_id, evt_cycle,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_code, evt_lane, evt_id, evt_cycle,
        output evt_ready
    );
endinterface

// File: rtl/marker_decode.sv
// rtl/marker_decode.sv - recognises slti x0,x0,imm INFO markers on one lane
module marker_decode
    import rob_marker_pkg::*;
(
    input  logic        valid,
    input  logic [31:0] inst,
    output logic        hit,
    output logic [3:0]  code
);
    assign code = inst[INFO_CODE_LSB+3:INFO_CODE_LSB];
    assign hit  = valid && (inst[19:0] == INFO_BASE[19:0]) &&
                  (inst[31:24] == 8'h00) && (code <= INFO_CODE_MAX);
endmodule

// File: rtl/rob_marker_serializer.sv
// rtl/rob_marker_serializer.sv - queues per-lane INFO markers and streams them one per cycle
module rob_marker_serializer
    import rob_marker_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 8,
    parameter int ID_W  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [LANES-1:0]        lane_valid,
    input  logic [32*LANES-1:0]     lane_inst,
    rob_marker_serializer_if.master evt,
    output logic                    overflow,
    output logic [15:0]             drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [LANES-1:0] hit;
    logic [3:0]       code [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_dec
        marker_decode u_dec (
            .valid (lane_valid[g]),
            .inst  (lane_inst[32*g +: 32]),
            .hit   (hit[g]),
            .code  (code[g])
        );
    end

    logic [CNT_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [ID_W-1:0]   next_id_q, next_id_d;
    logic [31:0]       cycle_q, cycle_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;
    marker_evt_t       mem_q [DEPTH];
    marker_evt_t       mem_d [DEPTH];

    logic [CNT_W-1:0]  free, push_n, drop_n, waddr;
    logic [16:0]       drop_sum;
    logic              empty, pop;
    logic [PTR_W-1:0]  rd_idx;

    assign empty  = (wr_q == rd_q);
    assign rd_idx = rd_q[PTR_W-1:0];
    assign pop    = !empty && evt.evt_ready;

    always_comb begin
        // Space is judged at start of cycle, so a concurrent pop never admits an extra push.
        free     = CNT_W'(DEPTH) - (wr_q - rd_q);
        push_n   = '0;
        drop_n   = '0;
        waddr    = wr_q;
        mem_d    = mem_q;
        for (int i = 0; i < LANES; i++) begin
            if (hit[i]) begin
                if (push_n < free) begin
                    waddr = wr_q + push_n;
                    mem_d[waddr[PTR_W-1:0]] = '{
                        code:  marker_code_e'(code[i]),
                        lane:  2'(i),
                        id:    EVT_ID_MAX_W'(next_id_q + ID_W'(push_n)),
                        cycle: cycle_q
                    };
                    push_n = push_n + CNT_W'(1);
                end else begin
                    drop_n = drop_n + CNT_W'(1);
                end
            end
        end
        wr_d       = wr_q + push_n;
        rd_d       = rd_q + CNT_W'(pop);
        next_id_d  = next_id_q + ID_W'(push_n);
        cycle_d    = cycle_q + 32'd1;
        drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_n);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        overflow_d = overflow_q || (drop_n != '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q       <= '0;
            rd_q       <= '0;
            next_id_q  <= '0;
            cycle_q    <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            next_id_q  <= next_id_d;
            cycle_q    <= cycle_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: outputs are masked whenever the pointers say empty.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign evt.evt_valid = !empty;
    assign evt.evt_code  = empty ? 4'h0     : mem_q[rd_idx].code;
    assign evt.evt_lane  = empty ? 2'd0     : mem_q[rd_idx].lane;
    assign evt.evt_id    = empty ? '0       : mem_q[rd_idx].id[ID_W-1:0];
    assign evt.evt_cycle = empty ? 32'd0    : mem_q[rd_idx].cycle;
    assign overflow      = overflow_q;
    assign drop_cnt      = drop_cnt_q;
endmodule
